div8_signed: RTL

DIV8_SIGNED -- requirements
Module: div8_signed

---
 rtl/div8_pkg.sv | 17 +
 rtl/div_step.sv | 26 ++
 rtl/div8_signed.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div8_pkg.sv
// Shared width, FSM state type and magnitude helper for the signed 8-bit divider.
package div8_pkg;
    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Unsigned magnitude; -128 maps to 0x80, which is exact when read as unsigned.
    function automatic logic [WIDTH-1:0] abs_u(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift a quotient bit into the
// partial remainder, subtract the divisor when it fits.
module div_step
    import div8_pkg::*;
(
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH:0]   i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH+1:0] w_shift;
    logic             w_fits;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, i_dvs});

    always_comb begin
        o_rem = w_shift[WIDTH:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (w_fits) begin
            o_rem = w_shift[WIDTH:0] - i_dvs;
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div8_signed.sv
// Sequential signed 8-bit divider: sign/magnitude restoring division, 8 steps,
// results truncate toward zero with remainder taking the dividend's sign.
//
// state | meaning
// IDLE  | wait for Run low; CLR_LDB loads the divisor register
// LOAD  | latch magnitudes and signs, clear remainder and step counter
// ITER  | one restoring step per clock, 8 clocks
// FIX   | apply signs, handle divide-by-zero / overflow, publish results
// DONE  | hold results until Run returns high
module div8_signed
    import div8_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       CLR_LDB,
    input  logic [7:0] Switches,
    output logic [7:0] D_out,
    output logic [7:0] Q_out,
    output logic [7:0] R_out,
    output logic       Busy,
    output logic       DivZero,
    output logic       Ovf
);
    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH:0]   r_dmag;
    logic             r_sgn_n;
    logic             r_sgn_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;
    logic             r_ovf;
    logic             w_busy;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_qfix;
    logic [WIDTH-1:0] w_rfix;
    logic             w_dz;
    logic             w_ovf;

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dmag),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!Run) w_next = LOAD;
            LOAD:    w_next = ITER;
            ITER:    if (r_cnt == 3'd7) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (Run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == LOAD) || (r_state == ITER) || (r_state == FIX);
    end

    assign w_qfix = (r_sgn_n ^ r_sgn_d) ? (~r_quo + 1'b1) : r_quo;
    assign w_rfix = r_sgn_n ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
    assign w_dz   = (r_divisor == '0);
    assign w_ovf  = (r_dividend == 8'h80) && (r_divisor == 8'hFF);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt      <= '0;
            r_d        <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dmag     <= '0;
            r_sgn_n    <= 1'b0;
            r_sgn_d    <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!CLR_LDB) r_d <= Switches;
                    // Divisor snapshot taken here so a same-edge load does not affect this division.
                    if (!Run) begin
                        r_dividend <= Switches;
                        r_divisor  <= r_d;
                    end
                end
                LOAD: begin
                    r_sgn_n <= r_dividend[WIDTH-1];
                    r_sgn_d <= r_divisor[WIDTH-1];
                    r_quo   <= abs_u(r_dividend);
                    r_dmag  <= {1'b0, abs_u(r_divisor)};
                    r_rem   <= '0;
                    r_cnt   <= '0;
                end
                ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 3'd1;
                end
                FIX: begin
                    r_dz  <= w_dz;
                    r_ovf <= w_ovf;
                    if (w_dz) begin
                        r_q <= 8'hFF;
                        r_r <= r_dividend;
                    end else begin
                        r_q <= w_qfix;
                        r_r <= w_rfix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign D_out   = r_d;
    assign Q_out   = r_q;
    assign R_out   = r_r;
    assign Busy    = w_busy;
    assign DivZero = r_dz;
    assign Ovf     = r_ovf;
endmodule
